// File: rtl/quad_edge_rasterizer_if.sv
// ---------------------------------------------------------------------------
// quad_edge_rasterizer_if
//
// Purpose:
//    Bundles the two conversations the quad rasterizer has with its
//    neighbours. The loader side carries the draw request, the four vertices
//    and the completion pulse. The framebuffer side carries the pixel
//    valid/ready handshake and its coordinates.
//
// Signals:
//    draw_lines        loader request, level, held high until line_done
//    x0..y3            quad vertices, valid while draw_lines is high
//    plot_ready        framebuffer writer accepts the current pixel
//    plot              pixel valid
//    px, py            pixel coordinates
//    busy              rasterizer is working on a quad
//    line_done         one-cycle pulse when the outline is complete
//
// Modports:
//    master            loader / framebuffer side (drives requests and ready)
//    slave             the rasterizer itself
// ---------------------------------------------------------------------------
interface quad_edge_rasterizer_if #(
   parameter int COORD_W = 10
);

   logic               draw_lines;
   logic [COORD_W-1:0] x0;
   logic [COORD_W-1:0] y0;
   logic [COORD_W-1:0] x1;
   logic [COORD_W-1:0] y1;
   logic [COORD_W-1:0] x2;
   logic [COORD_W-1:0] y2;
   logic [COORD_W-1:0] x3;
   logic [COORD_W-1:0] y3;
   logic               plot_ready;
   logic               plot;
   logic [COORD_W-1:0] px;
   logic [COORD_W-1:0] py;
   logic               busy;
   logic               line_done;

   modport master (
      output draw_lines, x0, y0, x1, y1, x2, y2, x3, y3, plot_ready,
      input  plot, px, py, busy, line_done
   );

   modport slave (
      input  draw_lines, x0, y0, x1, y1, x2, y2, x3, y3, plot_ready,
      output plot, px, py, busy, line_done
   );

endinterface

// File: rtl/quad_edge_rasterizer.sv
// ---------------------------------------------------------------------------
// quad_edge_rasterizer
//
// Purpose:
//    Rasterizes the closed outline v0->v1->v2->v3->v0 of a quadrilateral with
//    integer Bresenham. It emits one pixel per cycle over a valid/ready
//    handshake and pulses line_done when the fourth edge has been walked.
//    Pixels beyond X_MAX/Y_MAX still cost one cycle each, but they are not
//    presented to the framebuffer writer.
//
// Ports:
//    clk               system clock
//    rst               synchronous, active-high reset
//    bus (slave)       loader request/vertices/line_done plus the pixel
//                      handshake (plot, plot_ready, px, py) and busy
// ---------------------------------------------------------------------------
module quad_edge_rasterizer #(
   parameter int COORD_W = 10,
   parameter int X_MAX   = 639,
   parameter int Y_MAX   = 479
) (
   input  logic                   clk,
   input  logic                   rst,
   quad_edge_rasterizer_if.slave  bus
);

   // Two guard bits let |B-A| and the negated dy sit in signed arithmetic
   // without overflow.
   localparam int W = COORD_W + 2;
   localparam logic signed [W-1:0] ONE       = W'(1);
   localparam logic signed [W-1:0] MINUS_ONE = -W'(1);
   localparam logic signed [W-1:0] X_LIMIT   = W'(X_MAX);
   localparam logic signed [W-1:0] Y_LIMIT   = W'(Y_MAX);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      PLOT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            edgeIdx_q, edgeIdx_d;
   logic                  drawLines_q;
   logic [COORD_W-1:0]    vx_q [4];
   logic [COORD_W-1:0]    vx_d [4];
   logic [COORD_W-1:0]    vy_q [4];
   logic [COORD_W-1:0]    vy_d [4];
   logic signed [W-1:0]   cx_q, cx_d, cy_q, cy_d;
   logic signed [W-1:0]   dx_q, dx_d, dy_q, dy_d;
   logic signed [W-1:0]   err_q, err_d;
   logic                  sx_q, sx_d, sy_q, sy_d;

   logic                  start;
   logic [1:0]            edgeNext;
   logic signed [W-1:0]   ax, ay, bx, by;
   logic signed [W-1:0]   diffX, diffY, absX, absY;
   logic signed [W-1:0]   e2, stepX, stepY;
   logic                  clipped, atEnd, accept;

   // A request is a rising edge of the level draw_lines. The delay register
   // is cleared in reset so a request already high at release still counts.
   assign start    = bus.draw_lines & ~drawLines_q;
   assign edgeNext = edgeIdx_q + 2'd1;

   // Edge k runs from v[k] to v[k+1], with the 2-bit index wrapping back to v0.
   assign ax = $signed({2'b00, vx_q[edgeIdx_q]});
   assign ay = $signed({2'b00, vy_q[edgeIdx_q]});
   assign bx = $signed({2'b00, vx_q[edgeNext]});
   assign by = $signed({2'b00, vy_q[edgeNext]});

   // Edge setup terms: the absolute deltas used to load dx and dy.
   assign diffX = bx - ax;
   assign diffY = by - ay;
   assign absX  = diffX[W-1] ? -diffX : diffX;
   assign absY  = diffY[W-1] ? -diffY : diffY;

   // Bresenham step terms. The direction flags become +1/-1 increments.
   assign e2    = err_q <<< 1;
   assign stepX = sx_q ? ONE : MINUS_ONE;
   assign stepY = sy_q ? ONE : MINUS_ONE;

   // A clipped pixel is never offered to the writer, so it retires on its
   // own. A visible pixel waits for plot_ready.
   assign clipped = (cx_q > X_LIMIT) || (cy_q > Y_LIMIT);
   assign atEnd   = (cx_q == bx) && (cy_q == by);
   assign accept  = (state_q == PLOT) && (clipped || bus.plot_ready);

   // Outputs come straight from state and walker registers, so they only
   // change at accepted steps and hold steady while the writer stalls.
   assign bus.plot      = (state_q == PLOT) && !clipped;
   assign bus.px        = cx_q[COORD_W-1:0];
   assign bus.py        = cy_q[COORD_W-1:0];
   assign bus.busy      = (state_q != IDLE);
   assign bus.line_done = (state_q == DONE);

   // State register plus all walker and vertex registers. A reset returns
   // everything to idle, so an aborted quad never produces line_done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         edgeIdx_q   <= 2'd0;
         drawLines_q <= 1'b0;
         vx_q        <= '{default: '0};
         vy_q        <= '{default: '0};
         cx_q        <= '0;
         cy_q        <= '0;
         dx_q        <= '0;
         dy_q        <= '0;
         err_q       <= '0;
         sx_q        <= 1'b0;
         sy_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         edgeIdx_q   <= edgeIdx_d;
         drawLines_q <= bus.draw_lines;
         vx_q        <= vx_d;
         vy_q        <= vy_d;
         cx_q        <= cx_d;
         cy_q        <= cy_d;
         dx_q        <= dx_d;
         dy_q        <= dy_d;
         err_q       <= err_d;
         sx_q        <= sx_d;
         sy_q        <= sy_d;
      end
   end

   // Next-state logic. IDLE captures the vertices. SETUP loads one edge.
   // PLOT walks the edge, and both Bresenham updates are computed from the
   // old err so diagonal steps match the textbook form. DONE lasts one cycle
   // and drives the line_done pulse.
   always_comb begin
      state_d   = state_q;
      edgeIdx_d = edgeIdx_q;
      vx_d      = vx_q;
      vy_d      = vy_q;
      cx_d      = cx_q;
      cy_d      = cy_q;
      dx_d      = dx_q;
      dy_d      = dy_q;
      err_d     = err_q;
      sx_d      = sx_q;
      sy_d      = sy_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               vx_d[0]   = bus.x0;
               vy_d[0]   = bus.y0;
               vx_d[1]   = bus.x1;
               vy_d[1]   = bus.y1;
               vx_d[2]   = bus.x2;
               vy_d[2]   = bus.y2;
               vx_d[3]   = bus.x3;
               vy_d[3]   = bus.y3;
               edgeIdx_d = 2'd0;
               state_d   = SETUP;
            end
         end

         SETUP: begin
            cx_d    = ax;
            cy_d    = ay;
            dx_d    = absX;
            dy_d    = -absY;
            sx_d    = (bx >= ax);
            sy_d    = (by >= ay);
            err_d   = absX - absY;
            state_d = PLOT;
         end

         PLOT: begin
            if (accept) begin
               if (atEnd) begin
                  if (edgeIdx_q == 2'd3) begin
                     state_d = DONE;
                  end else begin
                     edgeIdx_d = edgeNext;
                     state_d   = SETUP;
                  end
               end else begin
                  if (e2 >= dy_q) begin
                     cx_d = cx_q + stepX;
                  end
                  if (e2 <= dx_q) begin
                     cy_d = cy_q + stepY;
                  end
                  err_d = err_q + ((e2 >= dy_q) ? dy_q : '0)
                                + ((e2 <= dx_q) ? dx_q : '0);
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_quad_edge_rasterizer.sv
// ---------------------------------------------------------------------------
// tb_quad_edge_rasterizer
//
// Purpose:
//    Directed bench for quad_edge_rasterizer. It drives hand-picked quads and
//    compares pixel streams, handshake holding, clipping and line_done timing
//    against hand-computed values.
//
// Ports:
//    none (top-level bench)
// ---------------------------------------------------------------------------
module tb_quad_edge_rasterizer;

   logic clk;
   logic rst;

   quad_edge_rasterizer_if #(.COORD_W(10)) bus ();

   quad_edge_rasterizer #(
      .COORD_W(10),
      .X_MAX  (639),
      .Y_MAX  (479)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int vectors;
   int miscompares;

   // Pixels observed during one quad, plus timing and handshake bookkeeping.
   logic [19:0] pixQ [$];
   int          doneCyc;
   int          donePulses;
   int          firstPlotCyc;
   int          holdBad;
   int          heldCount;
   int          clipLeak;
   int          busyAfter;
   int          idleBad;
   int          doneSeen;

   // Hand-walked outline of the square (10,10),(13,10),(13,13),(10,13).
   int sqX [16] = '{10, 11, 12, 13, 13, 13, 13, 13, 13, 12, 11, 10, 10, 10, 10, 10};
   int sqY [16] = '{10, 10, 10, 10, 10, 11, 12, 13, 13, 13, 13, 13, 13, 12, 11, 10};
   // Diagonal quad with v1=v2=v3, so edges 1 and 2 are degenerate.
   int dgX [10] = '{0, 1, 2, 3, 3, 3, 3, 2, 1, 0};
   int dgY [10] = '{0, 1, 1, 2, 2, 2, 2, 1, 1, 0};
   // Only the on-screen pixels of the clipped quad ever reach the writer.
   int clX [4]  = '{638, 639, 639, 638};

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: count it, and on a miss count a miscompare and report it.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Raise draw_lines with the given quad in the current cycle (C0), then
   // play the framebuffer writer until line_done plus one cycle, or until
   // the cycle budget runs out. stallIdx/stallCycles hold plot_ready low on
   // the given pixel. clipReady holds plot_ready low while px is off-screen.
   task automatic applyStimulus(input int ax0, input int ay0, input int ax1, input int ay1,
                                input int ax2, input int ay2, input int ax3, input int ay3,
                                input int stallIdx, input int stallCycles, input bit clipReady);
      int       cyc;
      int       stallLeft;
      bit       prevStall;
      bit       finished;
      bit       ready;
      logic [9:0] prevPx;
      logic [9:0] prevPy;
      pixQ.delete();
      doneCyc      = -1;
      donePulses   = 0;
      firstPlotCyc = -1;
      holdBad      = 0;
      heldCount    = 0;
      clipLeak     = 0;
      busyAfter    = -1;
      cyc          = 0;
      stallLeft    = stallCycles;
      prevStall    = 1'b0;
      finished     = 1'b0;
      prevPx       = '0;
      prevPy       = '0;
      bus.x0 = 10'(ax0);
      bus.y0 = 10'(ay0);
      bus.x1 = 10'(ax1);
      bus.y1 = 10'(ay1);
      bus.x2 = 10'(ax2);
      bus.y2 = 10'(ay2);
      bus.x3 = 10'(ax3);
      bus.y3 = 10'(ay3);
      bus.draw_lines = 1'b1;
      bus.plot_ready = 1'b1;
      while (!finished && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
         ready = 1'b1;
         if (clipReady) begin
            ready = (bus.px <= 10'd639);
         end else if (bus.plot && pixQ.size() == stallIdx && stallLeft > 0) begin
            ready = 1'b0;
            stallLeft--;
         end
         bus.plot_ready = ready;
         #1;
         if (prevStall && !(bus.plot && bus.px == prevPx && bus.py == prevPy)) holdBad++;
         if (bus.plot && bus.px == 10'd11 && bus.py == 10'd10) heldCount++;
         if (bus.plot && bus.px > 10'd639) clipLeak++;
         if (bus.plot && firstPlotCyc < 0) firstPlotCyc = cyc;
         if (bus.plot && ready) pixQ.push_back({bus.px, bus.py});
         prevStall = bus.plot && !ready;
         prevPx    = bus.px;
         prevPy    = bus.py;
         if (bus.line_done) begin
            donePulses++;
            if (doneCyc < 0) doneCyc = cyc;
         end
         if (doneCyc >= 0 && cyc == doneCyc + 1) begin
            busyAfter = int'(bus.busy);
            finished  = 1'b1;
         end
      end
      bus.plot_ready = 1'b1;
   endtask

   // Directed sequence: reset, square, restart rules, diagonal,
   // backpressure, clipping, mid-quad reset, and start at reset release.
   initial begin
      vectors     = 0;
      miscompares = 0;
      idleBad     = 0;
      doneSeen    = 0;
      rst = 1'b1;
      bus.draw_lines = 1'b0;
      bus.plot_ready = 1'b1;
      bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
      bus.x2 = '0; bus.y2 = '0; bus.x3 = '0; bus.y3 = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      $display("[TB] reset state");
      checkOutput("rst_plot", int'(bus.plot), 0);
      checkOutput("rst_px", int'(bus.px), 0);
      checkOutput("rst_py", int'(bus.py), 0);
      checkOutput("rst_busy", int'(bus.busy), 0);
      checkOutput("rst_done", int'(bus.line_done), 0);

      $display("[TB] square, plot_ready high");
      applyStimulus(10, 10, 13, 10, 13, 13, 10, 13, -1, 0, 1'b0);
      checkOutput("sq_count", pixQ.size(), 16);
      for (int i = 0; i < 16; i++) begin
         checkOutput("sq_x", (i < pixQ.size()) ? int'(pixQ[i][19:10]) : -1, sqX[i]);
         checkOutput("sq_y", (i < pixQ.size()) ? int'(pixQ[i][9:0]) : -1, sqY[i]);
      end
      checkOutput("sq_first", firstPlotCyc, 2);
      checkOutput("sq_done_cyc", doneCyc, 21);
      checkOutput("sq_done_pulses", donePulses, 1);
      checkOutput("sq_busy_after", busyAfter, 0);

      $display("[TB] draw_lines held high after line_done");
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.plot || bus.busy) idleBad++;
      end
      checkOutput("hold_no_redraw", idleBad, 0);

      $display("[TB] toggle draw_lines for a new square");
      bus.draw_lines = 1'b0;
      tick();
      applyStimulus(10, 10, 13, 10, 13, 13, 10, 13, -1, 0, 1'b0);
      checkOutput("re_count", pixQ.size(), 16);
      checkOutput("re_first", firstPlotCyc, 2);
      checkOutput("re_done_cyc", doneCyc, 21);
      bus.draw_lines = 1'b0;
      tick();

      $display("[TB] diagonal quad");
      applyStimulus(0, 0, 3, 2, 3, 2, 3, 2, -1, 0, 1'b0);
      checkOutput("dg_count", pixQ.size(), 10);
      for (int i = 0; i < 10; i++) begin
         checkOutput("dg_x", (i < pixQ.size()) ? int'(pixQ[i][19:10]) : -1, dgX[i]);
         checkOutput("dg_y", (i < pixQ.size()) ? int'(pixQ[i][9:0]) : -1, dgY[i]);
      end
      checkOutput("dg_done_cyc", doneCyc, 15);
      bus.draw_lines = 1'b0;
      tick();

      $display("[TB] square with backpressure on the second pixel");
      applyStimulus(10, 10, 13, 10, 13, 13, 10, 13, 1, 3, 1'b0);
      checkOutput("bp_count", pixQ.size(), 16);
      for (int i = 0; i < 16; i++) begin
         checkOutput("bp_x", (i < pixQ.size()) ? int'(pixQ[i][19:10]) : -1, sqX[i]);
         checkOutput("bp_y", (i < pixQ.size()) ? int'(pixQ[i][9:0]) : -1, sqY[i]);
      end
      checkOutput("bp_held_cycles", heldCount, 4);
      checkOutput("bp_hold_stable", holdBad, 0);
      checkOutput("bp_done_cyc", doneCyc, 24);
      bus.draw_lines = 1'b0;
      tick();

      $display("[TB] clipped quad");
      applyStimulus(638, 5, 641, 5, 641, 5, 641, 5, -1, 0, 1'b1);
      checkOutput("cl_count", pixQ.size(), 4);
      for (int i = 0; i < 4; i++) begin
         checkOutput("cl_x", (i < pixQ.size()) ? int'(pixQ[i][19:10]) : -1, clX[i]);
      end
      checkOutput("cl_leak", clipLeak, 0);
      checkOutput("cl_done_cyc", doneCyc, 15);
      checkOutput("cl_done_pulses", donePulses, 1);
      bus.draw_lines = 1'b0;
      tick();

      $display("[TB] reset during edge 1");
      bus.x0 = 10'd10; bus.y0 = 10'd10; bus.x1 = 10'd13; bus.y1 = 10'd10;
      bus.x2 = 10'd13; bus.y2 = 10'd13; bus.x3 = 10'd10; bus.y3 = 10'd13;
      bus.draw_lines = 1'b1;
      repeat (8) tick();
      checkOutput("mid_edge1_px", int'(bus.px), 13);
      checkOutput("mid_edge1_py", int'(bus.py), 11);
      rst = 1'b1;
      tick();
      checkOutput("mid_rst_plot", int'(bus.plot), 0);
      checkOutput("mid_rst_busy", int'(bus.busy), 0);
      checkOutput("mid_rst_done", int'(bus.line_done), 0);
      rst = 1'b0;
      bus.draw_lines = 1'b0;
      doneSeen = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (bus.line_done) doneSeen++;
      end
      checkOutput("mid_no_done", doneSeen, 0);

      $display("[TB] draw_lines high at reset release");
      rst = 1'b1;
      bus.draw_lines = 1'b1;
      tick();
      checkOutput("rel_busy_in_rst", int'(bus.busy), 0);
      rst = 1'b0;
      tick();
      checkOutput("rel_busy", int'(bus.busy), 1);
      doneSeen = 0;
      for (int i = 0; i < 60 && doneSeen == 0; i++) begin
         tick();
         if (bus.line_done) doneSeen++;
      end
      checkOutput("rel_done", doneSeen, 1);
      bus.draw_lines = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/quad_edge_rasterizer.md
Name: quad_edge_rasterizer

Overview:
Downstream consumer of the vertex loader. On a rising edge of draw_lines it latches the four vertices and rasterizes the closed quadrilateral outline v0->v1->v2->v3->v0 with integer Bresenham. It emits one pixel per cycle to the framebuffer writer over a valid/ready handshake. When the fourth edge completes it pulses line_done back to the loader.

Parameters:
COORD_W, 10, coordinate width in bits (unsigned)
X_MAX, 639, largest on-screen x; larger x is clipped
Y_MAX, 479, largest on-screen y; larger y is clipped

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
draw_lines  input  1  loader request; level, held high until line_done
x0,y0,x1,y1,x2,y2,x3,y3  input  COORD_W each  quad vertices, valid while draw_lines high
plot_ready  input  1  framebuffer writer accepts the current pixel
plot  output  1  pixel valid
px  output  COORD_W  pixel x
py  output  COORD_W  pixel y
busy  output  1  high from start detection through line_done
line_done  output  1  one-cycle pulse, outline complete

Behaviour:
- Reset (only rst; synchronous): plot=0, px=0, py=0, busy=0, line_done=0, state=IDLE, edge index=0, draw_lines delay register=0.
- Start: start = draw_lines & ~draw_lines_q.
  - Accepted only in IDLE. Rising edges while busy are ignored.
  - All 8 vertices are captured on the start cycle. Input changes afterwards are ignored until the next start.
  - A draw_lines that is already high when rst releases counts as a rising edge.
- States:
  - IDLE: on start, capture vertices, set busy=1, edge=0, go to SETUP.
  - SETUP (1 cycle): load the current edge (A,B), where edge k runs from v[k] to v[(k+1) mod 4].
    - cx=Ax, cy=Ay.
    - dx=|Bx-Ax|, dy=-|By-Ay|, sx/sy = +1 or -1, err=dx+dy.
    - Arithmetic is signed, COORD_W+2 bits; no overflow is possible.
    - Go to PLOT.
  - PLOT: present (cx,cy).
    - A pixel is accepted when (plot & plot_ready), or immediately if the pixel is clipped.
    - On acceptance: if (cx,cy)==(Bx,By), the edge is finished. If edge==3, go to DONE; else increment edge and go to SETUP.
    - Otherwise step: e2=2*err; if e2>=dy then err+=dy, cx+=sx; if e2<=dx then err+=dx, cy+=sy. Both updates use the old err.
  - DONE (1 cycle): line_done=1, busy=0 at the next edge, go to IDLE.
- Clipping: if cx>X_MAX or cy>Y_MAX, plot=0 for that pixel. The pixel still costs one PLOT cycle and does not wait for plot_ready.
- Handshake: while plot=1 and plot_ready=0, px, py, plot and all walker state hold stable. plot is never retracted before acceptance.
- Endpoints: each edge plots inclusively, so every shared vertex is emitted twice.
  - Pixel count per edge = max(dx,|dy|)+1.
  - A degenerate edge (A==B) emits exactly one pixel.
- Timing with plot_ready tied high: C0 = the cycle draw_lines is first sampled high.
  - SETUP in C1, first plot in C2.
  - Total cycles to line_done = 4 SETUP + total pixels + 1. line_done is high in cycle C1+4+N, where N is the total pixel count.
- Mid-operation reset: everything returns to reset values on the next clock. No line_done is issued for the aborted quad.

Test Plan:
- Square v=(10,10),(13,10),(13,13),(10,13), plot_ready=1:
  - edge0 emits (10,10),(11,10),(12,10),(13,10).
  - 16 plots total; last plot is (10,10).
  - First plot in C2; line_done a single pulse in C21; busy low in C22.
- Diagonal v0=(0,0), v1=v2=v3=(3,2):
  - edge0 emits (0,0),(1,1),(2,1),(3,2).
  - edges 1 and 2 emit (3,2) once each.
  - edge3 emits (3,2),(2,1),(1,1),(0,0).
  - 10 plots total.
- Backpressure on the square: plot_ready low for 3 cycles on the 2nd pixel -> (11,10) held stable with plot=1 for 4 cycles, no pixel lost or duplicated, line_done delayed to C24.
- Clipping: v=(638,5),(641,5),(641,5),(641,5) -> plots (638,5),(639,5) only; (640,5) and (641,5) are suppressed with plot=0 and take 1 cycle each regardless of plot_ready; line_done still pulses.
- Restart and reset:
  - draw_lines held high for 5 cycles after line_done -> no second draw.
  - Toggle low then high -> new draw starts.
  - Assert rst during edge1 -> plot, busy and line_done are 0 in the next cycle, and no line_done pulse follows.
